audio_frame_buffer: RTL and testbench

Parametrised capture buffer between the audio codec driver and the FFT datapath. It takes one stereo sample pair per `advance` strobe and selects or mixes the channels. It decimates by a runtime factor, then writes the result into a ping-pong pair of frame banks. Completed frames are offered to the consumer through a valid/done handshake, and overruns are flagged rather than corrupting a frame under read.

---
 rtl/audio_frame_buffer_if.sv | 35 +++
 rtl/audio_frame_buffer.sv | 170 +++++++++++++++++
 tb/tb_audio_frame_buffer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/audio_frame_buffer_if.sv
// rtl/audio_frame_buffer_if.sv - capture and read-side signal bundle for audio_frame_buffer
interface audio_frame_buffer_if #(
    parameter int WIDTH     = 24,
    parameter int FRAME_LEN = 512,
    parameter int DECIM_W   = 8
);
    localparam int AW = $clog2(FRAME_LEN);

    logic               enable;
    logic               advance;
    logic [WIDTH-1:0]   left_in;
    logic [WIDTH-1:0]   right_in;
    logic [1:0]         ch_mode;
    logic [DECIM_W-1:0] decim;
    logic [AW-1:0]      rd_addr;
    logic [WIDTH-1:0]   rd_data;
    logic               frame_valid;
    logic               frame_done;
    logic               overrun;
    logic               clr_overrun;
    logic [15:0]        drop_count;
    logic [7:0]         frame_seq;

    modport master (
        output enable, advance, left_in, right_in, ch_mode, decim,
               rd_addr, frame_done, clr_overrun,
        input  rd_data, frame_valid, overrun, drop_count, frame_seq
    );

    modport slave (
        input  enable, advance, left_in, right_in, ch_mode, decim,
               rd_addr, frame_done, clr_overrun,
        output rd_data, frame_valid, overrun, drop_count, frame_seq
    );
endinterface

// File: rtl/audio_frame_buffer.sv
// rtl/audio_frame_buffer.sv - channel select, decimation and ping-pong frame capture
module audio_frame_buffer #(
    parameter int WIDTH     = 24,
    parameter int FRAME_LEN = 512,
    parameter int DECIM_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    audio_frame_buffer_if.slave  bus
);
    localparam int AW = $clog2(FRAME_LEN);
    localparam logic [0:0]    S_FILL    = 1'b0;
    localparam logic [0:0]    S_STALL   = 1'b1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_LEN - 1);

    // Channel selection; the mix keeps the floor of the average
    logic [WIDTH:0]   mix_sum;
    logic [WIDTH-1:0] sample;

    assign mix_sum = {bus.left_in[WIDTH-1], bus.left_in}
                   + {bus.right_in[WIDTH-1], bus.right_in};

    always_comb begin
        sample = bus.left_in;
        case (bus.ch_mode)
            2'b01:   sample = bus.right_in;
            2'b10:   sample = mix_sum[WIDTH:1];
            default: sample = bus.left_in;
        endcase
    end

    // Decimation: a new factor is only picked up at a group boundary
    logic [DECIM_W-1:0] dcnt;
    logic [DECIM_W-1:0] decim_eff;
    logic               strobe;
    logic               wrap;
    logic               kept;

    assign strobe = bus.advance & bus.enable;
    assign wrap   = (dcnt == decim_eff - DECIM_W'(1));
    assign kept   = strobe & (dcnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dcnt      <= '0;
            decim_eff <= DECIM_W'(1);
        end else if (strobe) begin
            if (wrap) begin
                dcnt      <= '0;
                decim_eff <= (bus.decim == '0) ? DECIM_W'(1) : bus.decim;
            end else begin
                dcnt <= dcnt + DECIM_W'(1);
            end
        end
    end

    // Bank flags and pointers
    logic [1:0]    full;
    logic [1:0]    full_rel;
    logic [1:0]    full_nxt;
    logic [1:0]    rel_mask;
    logic          wr_bank;
    logic          rd_bank;
    logic [AW-1:0] wptr;
    logic [0:0]    state;
    logic [7:0]    seq_q;
    logic          rel_rd;
    logic          wr_en;
    logic          drop;
    logic          frame_complete;
    logic          other_free;

    assign rel_rd         = bus.frame_done & full[rd_bank];
    assign rel_mask       = rel_rd ? (2'b01 << rd_bank) : 2'b00;
    assign full_rel       = full & ~rel_mask;
    // A release in the same cycle counts as free, so completion never stalls on it
    assign other_free     = ~full_rel[~wr_bank];
    assign wr_en          = kept & (state == S_FILL);
    assign drop           = kept & (state == S_STALL);
    assign frame_complete = wr_en & (wptr == LAST_ADDR);

    always_comb begin
        full_nxt = full_rel;
        if (frame_complete) begin
            full_nxt[wr_bank] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full    <= 2'b00;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wptr    <= '0;
            state   <= S_FILL;
            seq_q   <= 8'd0;
        end else begin
            full <= full_nxt;
            if (rel_rd) begin
                rd_bank <= ~rd_bank;
            end
            case (state)
                S_FILL: begin
                    if (frame_complete) begin
                        seq_q <= seq_q + 8'd1;
                        wptr  <= '0;
                        if (other_free) begin
                            wr_bank <= ~wr_bank;
                        end else begin
                            state <= S_STALL;
                        end
                    end else if (wr_en) begin
                        wptr <= wptr + AW'(1);
                    end
                end
                S_STALL: begin
                    if (other_free) begin
                        wr_bank <= ~wr_bank;
                        wptr    <= '0;
                        state   <= S_FILL;
                    end
                end
                default: state <= S_FILL;
            endcase
        end
    end

    // Overrun bookkeeping; clearing wins over a same-cycle drop
    logic        overrun_q;
    logic [15:0] drop_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_q <= 1'b0;
            drop_q    <= 16'd0;
        end else if (bus.clr_overrun) begin
            overrun_q <= 1'b0;
            drop_q    <= 16'd0;
        end else if (drop) begin
            overrun_q <= 1'b1;
            if (drop_q != 16'hFFFF) begin
                drop_q <= drop_q + 16'd1;
            end
        end
    end

    // Frame storage: both banks share one array addressed by {bank, index}
    logic [WIDTH-1:0] mem [2*FRAME_LEN];
    logic [WIDTH-1:0] rd_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_bank, wptr}] <= sample;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q <= '0;
        end else begin
            rd_q <= mem[{rd_bank, bus.rd_addr}];
        end
    end

    assign bus.rd_data     = rd_q;
    assign bus.frame_valid = full[rd_bank];
    assign bus.overrun     = overrun_q;
    assign bus.drop_count  = drop_q;
    assign bus.frame_seq   = seq_q;
endmodule

// File: tb/tb_audio_frame_buffer.sv
// tb/tb_audio_frame_buffer.sv - scoreboard and vector-table bench for audio_frame_buffer
module tb_audio_frame_buffer;
    localparam int WIDTH = 24;
    localparam int FLEN  = 8;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    audio_frame_buffer_if #(.WIDTH(WIDTH), .FRAME_LEN(FLEN), .DECIM_W(8)) bus ();

    audio_frame_buffer #(.WIDTH(WIDTH), .FRAME_LEN(FLEN), .DECIM_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]  mode;
        logic [23:0] l;
        logic [23:0] r;
        logic [23:0] exp;
    } mix_vec_t;

    mix_vec_t    mix_tab [8];
    logic [23:0] sb [$];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic strobe(input logic [23:0] l, input logic [23:0] r, input logic done);
        bus.advance    = 1'b1;
        bus.left_in    = l;
        bus.right_in   = r;
        bus.frame_done = done;
        @(posedge clk);
        #1;
        bus.advance    = 1'b0;
        bus.frame_done = 1'b0;
    endtask

    task automatic pulse_done();
        bus.frame_done = 1'b1;
        @(posedge clk);
        #1;
        bus.frame_done = 1'b0;
    endtask

    task automatic read_frame(input string name);
        logic [23:0] exp;
        for (int i = 0; i < FLEN; i++) begin
            bus.rd_addr = 3'(i);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL %s[%0d]: got 0x%0h expected scoreboard entry, queue empty", name, i, bus.rd_data);
            end else begin
                exp = sb.pop_front();
                check($sformatf("%s[%0d]", name, i), 32'(bus.rd_data), 32'(exp));
            end
        end
    endtask

    initial begin
        mix_tab[0] = '{2'b10, 24'h000003, 24'hFFFFFF, 24'h000001};
        mix_tab[1] = '{2'b10, 24'hFFFFFD, 24'h000000, 24'hFFFFFE};
        mix_tab[2] = '{2'b10, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF};
        mix_tab[3] = '{2'b01, 24'h000011, 24'h000022, 24'h000022};
        mix_tab[4] = '{2'b00, 24'h000033, 24'h000044, 24'h000033};
        mix_tab[5] = '{2'b11, 24'h000055, 24'h000066, 24'h000055};
        mix_tab[6] = '{2'b10, 24'h800000, 24'h800000, 24'h800000};
        mix_tab[7] = '{2'b10, 24'h000004, 24'h000002, 24'h000003};

        reset           = 1'b1;
        bus.enable      = 1'b1;
        bus.advance     = 1'b0;
        bus.left_in     = '0;
        bus.right_in    = '0;
        bus.ch_mode     = 2'b00;
        bus.decim       = 8'd1;
        bus.rd_addr     = '0;
        bus.frame_done  = 1'b0;
        bus.clr_overrun = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        check("reset_rd_data", 32'(bus.rd_data), 0);
        check("reset_frame_valid", 32'(bus.frame_valid), 0);
        check("reset_overrun", 32'(bus.overrun), 0);
        check("reset_drop_count", 32'(bus.drop_count), 0);
        check("reset_frame_seq", 32'(bus.frame_seq), 0);

        // Basic fill; a strobe with enable low must not be stored
        bus.enable = 1'b0;
        strobe(24'd999, 24'd0, 1'b0);
        bus.enable = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            strobe(24'(i), 24'd0, 1'b0);
            sb.push_back(24'(i));
        end
        check("basic_valid_before_last", 32'(bus.frame_valid), 0);
        // decim=3 is latched by the wrap of this last factor-1 strobe
        bus.decim = 8'd3;
        strobe(24'd8, 24'd0, 1'b0);
        sb.push_back(24'd8);
        check("basic_valid", 32'(bus.frame_valid), 1);
        check("basic_seq", 32'(bus.frame_seq), 1);
        read_frame("basic");
        pulse_done();
        check("basic_valid_after_done", 32'(bus.frame_valid), 0);

        // Decimation by 3 over 0..23
        for (int i = 0; i < 24; i++) begin
            strobe(24'(i), 24'd0, 1'b0);
            if (i % 3 == 0) sb.push_back(24'(i));
        end
        check("decim3_valid", 32'(bus.frame_valid), 1);
        check("decim3_seq", 32'(bus.frame_seq), 2);
        read_frame("decim3");
        pulse_done();

        // Factor changed mid-group applies only from the next group
        for (int v = 100; v <= 115; v++) begin
            if (v == 102) bus.decim = 8'd2;
            if (v == 114) bus.decim = 8'd0;
            strobe(24'(v), 24'd0, 1'b0);
        end
        foreach (mix_tab[k]) begin end
        sb.push_back(24'd100); sb.push_back(24'd103); sb.push_back(24'd105); sb.push_back(24'd107);
        sb.push_back(24'd109); sb.push_back(24'd111); sb.push_back(24'd113); sb.push_back(24'd115);
        check("decim_change_seq", 32'(bus.frame_seq), 3);
        read_frame("decim_change");
        pulse_done();

        // Channel mode table, decim held at 0 (acts as 1)
        for (int k = 0; k < 8; k++) begin
            bus.ch_mode = mix_tab[k].mode;
            strobe(mix_tab[k].l, mix_tab[k].r, 1'b0);
            sb.push_back(mix_tab[k].exp);
        end
        bus.ch_mode = 2'b00;
        check("mix_valid", 32'(bus.frame_valid), 1);
        check("mix_seq", 32'(bus.frame_seq), 4);
        read_frame("mix");
        pulse_done();

        // Overrun: three frames' worth with no release
        bus.decim = 8'd1;
        for (int v = 300; v < 324; v++) begin
            strobe(24'(v), 24'd0, 1'b0);
            if (v < 316) sb.push_back(24'(v));
        end
        check("ovr_overrun", 32'(bus.overrun), 1);
        check("ovr_drop_count", 32'(bus.drop_count), 8);
        check("ovr_seq", 32'(bus.frame_seq), 6);
        read_frame("ovr_bank0");
        pulse_done();
        check("ovr_valid_after_done", 32'(bus.frame_valid), 1);
        read_frame("ovr_bank1");
        for (int v = 400; v < 408; v++) begin
            strobe(24'(v), 24'd0, 1'b0);
            sb.push_back(24'(v));
        end
        check("ovr_drop_held", 32'(bus.drop_count), 8);
        pulse_done();
        check("ovr_resume_valid", 32'(bus.frame_valid), 1);
        read_frame("ovr_resume");
        bus.clr_overrun = 1'b1;
        @(posedge clk);
        #1;
        bus.clr_overrun = 1'b0;
        check("clr_overrun", 32'(bus.overrun), 0);
        check("clr_drop_count", 32'(bus.drop_count), 0);
        pulse_done();
        check("ovr_final_valid", 32'(bus.frame_valid), 0);

        // Release of one bank in the cycle the other completes
        for (int v = 500; v < 508; v++) begin
            strobe(24'(v), 24'd0, 1'b0);
            sb.push_back(24'(v));
        end
        read_frame("sim_pre");
        pulse_done();
        for (int v = 600; v < 608; v++) begin
            strobe(24'(v), 24'd0, 1'b0);
            sb.push_back(24'(v));
        end
        read_frame("sim_bank0");
        for (int v = 700; v < 707; v++) begin
            strobe(24'(v), 24'd0, 1'b0);
            sb.push_back(24'(v));
        end
        strobe(24'd707, 24'd0, 1'b1);
        sb.push_back(24'd707);
        check("sim_valid", 32'(bus.frame_valid), 1);
        check("sim_drop_count", 32'(bus.drop_count), 0);
        check("sim_overrun", 32'(bus.overrun), 0);
        check("sim_seq", 32'(bus.frame_seq), 10);
        read_frame("sim_bank1");
        pulse_done();
        check("sim_valid_after_done", 32'(bus.frame_valid), 0);

        // Reset with a partial frame in flight
        for (int v = 800; v < 805; v++) strobe(24'(v), 24'd0, 1'b0);
        reset = 1'b1;
        #1;
        check("rst_mid_rd_data", 32'(bus.rd_data), 0);
        check("rst_mid_frame_valid", 32'(bus.frame_valid), 0);
        check("rst_mid_overrun", 32'(bus.overrun), 0);
        check("rst_mid_drop_count", 32'(bus.drop_count), 0);
        check("rst_mid_frame_seq", 32'(bus.frame_seq), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.decim = 8'd1;
        for (int v = 900; v < 908; v++) begin
            strobe(24'(v), 24'd0, 1'b0);
            sb.push_back(24'(v));
        end
        check("rst_refill_valid", 32'(bus.frame_valid), 1);
        check("rst_refill_seq", 32'(bus.frame_seq), 1);
        read_frame("rst_refill");

        check("scoreboard_drained", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
